data_bus_arbiter: RTL and testbench

- Two-master, one-slave arbiter for the data-side bus.
- Master 0 is the core LSU; master 1 is a secondary requester (program loader / debug port).
- Slave side drives the existing address decoder and the memory/LEDs behind it.
- Round-robin grant per request, fixed-latency response routing back to the issuing master, no slave back-pressure.

---
 rtl/data_bus_arbiter.sv | 119 +++++++++++
 tb/tb_data_bus_arbiter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/data_bus_arbiter.sv
// Two-master, one-slave data bus arbiter: round-robin grant, fixed-latency response routing.
// Optional master-1 bus lock for atomic loader bursts: define DATA_BUS_ARB_LOCK_EN.
module data_bus_arbiter #(
    parameter int RD_LATENCY = 1,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                m0_req_i,
    input  logic                m0_we_i,
    input  logic [ADDR_W-1:0]   m0_addr_i,
    input  logic [DATA_W-1:0]   m0_wdata_i,
    input  logic [DATA_W/8-1:0] m0_be_i,
    output logic                m0_gnt_o,
    output logic                m0_rvalid_o,
    output logic [DATA_W-1:0]   m0_rdata_o,
    input  logic                m1_req_i,
    input  logic                m1_we_i,
    input  logic [ADDR_W-1:0]   m1_addr_i,
    input  logic [DATA_W-1:0]   m1_wdata_i,
    input  logic [DATA_W/8-1:0] m1_be_i,
`ifdef DATA_BUS_ARB_LOCK_EN
    input  logic                m1_lock_i,
`endif
    output logic                m1_gnt_o,
    output logic                m1_rvalid_o,
    output logic [DATA_W-1:0]   m1_rdata_o,
    output logic                s_req_o,
    output logic                s_we_o,
    output logic [ADDR_W-1:0]   s_addr_o,
    output logic [DATA_W-1:0]   s_wdata_o,
    output logic [DATA_W/8-1:0] s_be_o,
    input  logic [DATA_W-1:0]   s_rdata_i
);

    // Handshake: a master holds req and its payload until gnt; the slave
    // accepts every cycle s_req_o=1 and answers RD_LATENCY cycles later.

    logic                  last_grant_q;
    logic                  lock_q;
    logic [RD_LATENCY-1:0] pipe_v_q;
    logic [RD_LATENCY-1:0] pipe_id_q;

    // Grants are gated by reset so the bus is quiet the moment rst_i rises.
    always_comb begin
        m0_gnt_o = 1'b0;
        m1_gnt_o = 1'b0;
        if (!rst_i) begin
            m1_gnt_o = m1_req_i & (lock_q | ~m0_req_i | ~last_grant_q);
            m0_gnt_o = m0_req_i & ~m1_gnt_o & ~lock_q;
        end
    end

    assign s_req_o = m0_gnt_o | m1_gnt_o;

    always_comb begin
        s_we_o    = 1'b0;
        s_addr_o  = '0;
        s_wdata_o = '0;
        s_be_o    = '0;
        if (m1_gnt_o) begin
            s_we_o    = m1_we_i;
            s_addr_o  = m1_addr_i;
            s_wdata_o = m1_wdata_i;
            s_be_o    = m1_be_i;
        end else if (m0_gnt_o) begin
            s_we_o    = m0_we_i;
            s_addr_o  = m0_addr_i;
            s_wdata_o = m0_wdata_i;
            s_be_o    = m0_be_i;
        end
    end

    // Reset value 1 lets master 0 win the first contention.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_grant_q <= 1'b1;
        end else if (s_req_o) begin
            last_grant_q <= m1_gnt_o;
        end
    end

`ifdef DATA_BUS_ARB_LOCK_EN
    // Lock is taken by a locked m1 grant and released as soon as m1_lock_i drops.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lock_q <= 1'b0;
        end else if (!m1_lock_i) begin
            lock_q <= 1'b0;
        end else if (m1_gnt_o) begin
            lock_q <= 1'b1;
        end
    end
`else
    assign lock_q = 1'b0;
`endif

    // Response pipeline: {valid, id} travels RD_LATENCY stages alongside the slave.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pipe_v_q  <= '0;
            pipe_id_q <= '0;
        end else begin
            pipe_v_q[0]  <= s_req_o;
            pipe_id_q[0] <= m1_gnt_o;
            for (int i = 1; i < RD_LATENCY; i++) begin
                pipe_v_q[i]  <= pipe_v_q[i-1];
                pipe_id_q[i] <= pipe_id_q[i-1];
            end
        end
    end

    assign m0_rvalid_o = pipe_v_q[RD_LATENCY-1] & ~pipe_id_q[RD_LATENCY-1];
    assign m1_rvalid_o = pipe_v_q[RD_LATENCY-1] &  pipe_id_q[RD_LATENCY-1];
    assign m0_rdata_o  = m0_rvalid_o ? s_rdata_i : '0;
    assign m1_rdata_o  = m1_rvalid_o ? s_rdata_i : '0;

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Bench for data_bus_arbiter: two instances (RD_LATENCY 1 and 3) share one stimulus stream.
// Lock scenarios are included when DATA_BUS_ARB_LOCK_EN is defined.
module tb_data_bus_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = DW / 8;

    // clock / reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          m0_req, m0_we, m1_req, m1_we, m1_lock;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [DW-1:0] m0_wdata, m1_wdata, s_rdata;
    logic [BW-1:0] m0_be, m1_be;

    logic          a_m0_gnt, a_m0_rvalid, a_m1_gnt, a_m1_rvalid, a_s_req, a_s_we;
    logic [DW-1:0] a_m0_rdata, a_m1_rdata, a_s_wdata;
    logic [AW-1:0] a_s_addr;
    logic [BW-1:0] a_s_be;
    logic          b_m0_gnt, b_m0_rvalid, b_m1_gnt, b_m1_rvalid, b_s_req, b_s_we;
    logic [DW-1:0] b_m0_rdata, b_m1_rdata, b_s_wdata;
    logic [AW-1:0] b_s_addr;
    logic [BW-1:0] b_s_be;

    data_bus_arbiter #(.RD_LATENCY(1), .ADDR_W(AW), .DATA_W(DW)) dut_a (
        .clk_i(clk), .rst_i(rst),
        .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata),
        .m0_be_i(m0_be), .m0_gnt_o(a_m0_gnt), .m0_rvalid_o(a_m0_rvalid), .m0_rdata_o(a_m0_rdata),
        .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata),
        .m1_be_i(m1_be),
`ifdef DATA_BUS_ARB_LOCK_EN
        .m1_lock_i(m1_lock),
`endif
        .m1_gnt_o(a_m1_gnt), .m1_rvalid_o(a_m1_rvalid), .m1_rdata_o(a_m1_rdata),
        .s_req_o(a_s_req), .s_we_o(a_s_we), .s_addr_o(a_s_addr), .s_wdata_o(a_s_wdata),
        .s_be_o(a_s_be), .s_rdata_i(s_rdata)
    );

    data_bus_arbiter #(.RD_LATENCY(3), .ADDR_W(AW), .DATA_W(DW)) dut_b (
        .clk_i(clk), .rst_i(rst),
        .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata),
        .m0_be_i(m0_be), .m0_gnt_o(b_m0_gnt), .m0_rvalid_o(b_m0_rvalid), .m0_rdata_o(b_m0_rdata),
        .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata),
        .m1_be_i(m1_be),
`ifdef DATA_BUS_ARB_LOCK_EN
        .m1_lock_i(m1_lock),
`endif
        .m1_gnt_o(b_m1_gnt), .m1_rvalid_o(b_m1_rvalid), .m1_rdata_o(b_m1_rdata),
        .s_req_o(b_s_req), .s_we_o(b_s_we), .s_addr_o(b_s_addr), .s_wdata_o(b_s_wdata),
        .s_be_o(b_s_be), .s_rdata_i(s_rdata)
    );

    // scoreboard: each entry is {issue_cycle[15:0], master_id}
    logic [16:0] exp_q1[$];
    logic [16:0] exp_q3[$];
    logic        exp_last, exp_lock, eg0, eg1;
    int          cyc, n_cmp, n_err;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $display("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
            $error("check %s differs: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic resp_exp(input int lat, input int qsize, input logic [16:0] front,
                            output logic v0, output logic v1);
        v0 = 1'b0;
        v1 = 1'b0;
        if (qsize > 0 && int'(front[16:1]) == cyc - lat) begin
            v0 = ~front[0];
            v1 = front[0];
        end
    endtask

    // driver: one bus cycle; inputs are already set, outputs sampled at the falling edge
    task automatic step();
        logic v0, v1;
        s_rdata = $urandom;
        @(negedge clk);
        eg1 = !rst && m1_req && (exp_lock || !m0_req || !exp_last);
        eg0 = !rst && m0_req && !eg1 && !exp_lock;
        if (rst) begin
            exp_q1.delete();
            exp_q3.delete();
        end
        chk("a_m0_gnt", a_m0_gnt, eg0);
        chk("a_m1_gnt", a_m1_gnt, eg1);
        chk("a_s_req", a_s_req, eg0 | eg1);
        chk("a_s_we", a_s_we, eg1 ? m1_we : (eg0 ? m0_we : 1'b0));
        chk("a_s_addr", a_s_addr, eg1 ? m1_addr : (eg0 ? m0_addr : '0));
        chk("a_s_wdata", a_s_wdata, eg1 ? m1_wdata : (eg0 ? m0_wdata : '0));
        chk("a_s_be", a_s_be, eg1 ? m1_be : (eg0 ? m0_be : '0));
        chk("b_m0_gnt", b_m0_gnt, eg0);
        chk("b_m1_gnt", b_m1_gnt, eg1);
        chk("b_s_addr", b_s_addr, eg1 ? m1_addr : (eg0 ? m0_addr : '0));

        resp_exp(1, exp_q1.size(), (exp_q1.size() > 0) ? exp_q1[0] : 17'd0, v0, v1);
        chk("a_m0_rvalid", a_m0_rvalid, v0);
        chk("a_m1_rvalid", a_m1_rvalid, v1);
        chk("a_m0_rdata", a_m0_rdata, v0 ? s_rdata : '0);
        chk("a_m1_rdata", a_m1_rdata, v1 ? s_rdata : '0);
        if (v0 | v1) void'(exp_q1.pop_front());

        resp_exp(3, exp_q3.size(), (exp_q3.size() > 0) ? exp_q3[0] : 17'd0, v0, v1);
        chk("b_m0_rvalid", b_m0_rvalid, v0);
        chk("b_m1_rvalid", b_m1_rvalid, v1);
        chk("b_m0_rdata", b_m0_rdata, v0 ? s_rdata : '0);
        chk("b_m1_rdata", b_m1_rdata, v1 ? s_rdata : '0);
        if (v0 | v1) void'(exp_q3.pop_front());

        if (eg0 | eg1) begin
            exp_q1.push_back({cyc[15:0], eg1});
            exp_q3.push_back({cyc[15:0], eg1});
        end
        if (rst) begin
            exp_last = 1'b1;
            exp_lock = 1'b0;
        end else begin
            if (eg0 | eg1) exp_last = eg1;
`ifdef DATA_BUS_ARB_LOCK_EN
            if (!m1_lock) exp_lock = 1'b0;
            else if (eg1) exp_lock = 1'b1;
`endif
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic set_m0(input logic req, input logic we, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata, input logic [BW-1:0] be);
        m0_req = req; m0_we = we; m0_addr = addr; m0_wdata = wdata; m0_be = be;
    endtask

    task automatic set_m1(input logic req, input logic we, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata, input logic [BW-1:0] be);
        m1_req = req; m1_we = we; m1_addr = addr; m1_wdata = wdata; m1_be = be;
    endtask

    task automatic idle(input int n);
        set_m0(1'b0, 1'b0, '0, '0, '0);
        set_m1(1'b0, 1'b0, '0, '0, '0);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        cyc = 0; n_cmp = 0; n_err = 0;
        exp_last = 1'b1; exp_lock = 1'b0; eg0 = 1'b0; eg1 = 1'b0;
        m1_lock = 1'b0; s_rdata = '0;
        set_m0(1'b0, 1'b0, '0, '0, '0);
        set_m1(1'b0, 1'b0, '0, '0, '0);

        // reset state
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;

        // lone m0 read of 0x10
        set_m0(1'b1, 1'b0, 32'h10, '0, 4'hF);
        step();
        idle(4);

        // both masters request from reset, held four cycles
        rst = 1'b1;
        step();
        rst = 1'b0;
        set_m0(1'b1, 1'b0, 32'h100, '0, 4'hF);
        set_m1(1'b1, 1'b0, 32'h200, '0, 4'hF);
        for (int i = 0; i < 4; i++) step();
        idle(4);

        // lone m1 write
        set_m1(1'b1, 1'b1, 32'h8000_0000, 32'h5, 4'hF);
        step();
        idle(4);

        // alternating grants with reset landing in flight
        set_m0(1'b1, 1'b1, 32'h44, 32'hAA, 4'h3);
        set_m1(1'b1, 1'b0, 32'h88, 32'h0, 4'hC);
        step();
        step();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        idle(5);

        // last_grant must survive a long idle stretch
        set_m0(1'b1, 1'b0, 32'h20, '0, 4'h1);
        step();
        idle(10);
        set_m0(1'b1, 1'b0, 32'h24, '0, 4'h2);
        set_m1(1'b1, 1'b0, 32'h28, '0, 4'h4);
        step();
        step();
        idle(4);

`ifdef DATA_BUS_ARB_LOCK_EN
        // locked m1 burst holds m0 off until the lock is released
        rst = 1'b1;
        step();
        rst = 1'b0;
        m1_lock = 1'b1;
        set_m1(1'b1, 1'b1, 32'h300, 32'h1, 4'hF);
        step();
        set_m1(1'b0, 1'b0, '0, '0, '0);
        set_m0(1'b1, 1'b0, 32'h400, '0, 4'hF);
        step();
        step();
        m1_lock = 1'b0;
        step();
        step();
        idle(4);
`endif

        // random traffic, payload held until granted
        for (int i = 0; i < 60; i++) begin
            if (!m0_req || eg0)
                set_m0(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom,
                       4'($urandom_range(0, 15)));
            if (!m1_req || eg1)
                set_m1(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom,
                       4'($urandom_range(0, 15)));
            step();
        end
        idle(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
